// File: rtl/uart_packet_deframer.sv
// UART packet deframer: hunts for a sync byte, then assembles a fixed-length payload into a flat vector.
// Define UART_DEFRAMER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module uart_packet_deframer #(
    parameter int          NUM_FIELDS  = 6,
    parameter int          FIELD_BYTES = 4,
    parameter int          TAIL_BYTES  = 1,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst_n,
    input  logic [7:0]                                        i_data_in,
    input  logic                                              i_data_rdy,
    output logic [(NUM_FIELDS*FIELD_BYTES+TAIL_BYTES)*8-1:0]  o_pkt_data,
    output logic                                              o_pkt_valid,
    input  logic                                              i_pkt_ready,
    output logic                                              o_timeout_err,
    output logic                                              o_overrun_err,
    output logic                                              o_chk_err,
    output logic [15:0]                                       o_pkt_count
);

    localparam int PKT_BYTES = NUM_FIELDS * FIELD_BYTES + TAIL_BYTES;
    localparam int PKT_W     = PKT_BYTES * 8;
    localparam int IDX_W     = $clog2(PKT_BYTES + 1);
    localparam int TMR_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_RECV,
`ifdef UART_DEFRAMER_CHECKSUM_EN
        S_CHK,
`endif
        S_HOLD
    } state_t;

    state_t             r_state, w_nextState;
    logic [PKT_W-1:0]   r_shadow, w_shadow;
    logic [PKT_W-1:0]   r_pktData, w_pktData;
    logic               r_pktValid, w_pktValid;
    logic [IDX_W-1:0]   r_byteIdx, w_byteIdx;
    logic [TMR_W-1:0]   r_timer, w_timer;
    logic [15:0]        r_pktCount, w_pktCount;
    logic               r_timeoutErr, w_timeoutErr;
    logic               r_overrunErr, w_overrunErr;
`ifdef UART_DEFRAMER_CHECKSUM_EN
    logic [7:0]         r_xorAcc, w_xorAcc;
    logic               r_chkErr, w_chkErr;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_HUNT;
            r_shadow     <= '0;
            r_pktData    <= '0;
            r_pktValid   <= 1'b0;
            r_byteIdx    <= '0;
            r_timer      <= '0;
            r_pktCount   <= '0;
            r_timeoutErr <= 1'b0;
            r_overrunErr <= 1'b0;
`ifdef UART_DEFRAMER_CHECKSUM_EN
            r_xorAcc     <= '0;
            r_chkErr     <= 1'b0;
`endif
        end else begin
            r_state      <= w_nextState;
            r_shadow     <= w_shadow;
            r_pktData    <= w_pktData;
            r_pktValid   <= w_pktValid;
            r_byteIdx    <= w_byteIdx;
            r_timer      <= w_timer;
            r_pktCount   <= w_pktCount;
            r_timeoutErr <= w_timeoutErr;
            r_overrunErr <= w_overrunErr;
`ifdef UART_DEFRAMER_CHECKSUM_EN
            r_xorAcc     <= w_xorAcc;
            r_chkErr     <= w_chkErr;
`endif
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_shadow     = r_shadow;
        w_pktData    = r_pktData;
        w_pktValid   = r_pktValid;
        w_byteIdx    = r_byteIdx;
        w_timer      = r_timer;
        w_pktCount   = r_pktCount;
        w_timeoutErr = 1'b0;
        w_overrunErr = 1'b0;
`ifdef UART_DEFRAMER_CHECKSUM_EN
        w_xorAcc     = r_xorAcc;
        w_chkErr     = 1'b0;
`endif
        case (r_state)
            S_HUNT: begin
                if (i_data_rdy && i_data_in == SYNC_BYTE) begin
                    w_nextState = S_RECV;
                    w_byteIdx   = '0;
                    w_timer     = '0;
`ifdef UART_DEFRAMER_CHECKSUM_EN
                    w_xorAcc    = '0;
`endif
                end
            end
            S_RECV: begin
                if (i_data_rdy) begin
                    w_shadow[8*r_byteIdx +: 8] = i_data_in;
                    w_timer = '0;
`ifdef UART_DEFRAMER_CHECKSUM_EN
                    w_xorAcc = r_xorAcc ^ i_data_in;
`endif
                    if (r_byteIdx == LAST_IDX) begin
`ifdef UART_DEFRAMER_CHECKSUM_EN
                        w_nextState = S_CHK;
`else
                        w_pktData   = w_shadow;
                        w_pktValid  = 1'b1;
                        w_nextState = S_HOLD;
`endif
                    end else begin
                        w_byteIdx = r_byteIdx + 1'b1;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_timeoutErr = 1'b1;
                    w_nextState  = S_HUNT;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
`ifdef UART_DEFRAMER_CHECKSUM_EN
            S_CHK: begin
                if (i_data_rdy) begin
                    w_timer = '0;
                    if (i_data_in == r_xorAcc) begin
                        w_pktData   = r_shadow;
                        w_pktValid  = 1'b1;
                        w_nextState = S_HOLD;
                    end else begin
                        w_chkErr    = 1'b1;
                        w_nextState = S_HUNT;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_timeoutErr = 1'b1;
                    w_nextState  = S_HUNT;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
`endif
            S_HOLD: begin
                // A sync byte arriving on the handshake cycle starts the next frame immediately
                if (r_pktValid && i_pkt_ready) begin
                    w_pktValid = 1'b0;
                    w_pktCount = r_pktCount + 16'd1;
                    if (i_data_rdy && i_data_in == SYNC_BYTE) begin
                        w_nextState = S_RECV;
                        w_byteIdx   = '0;
                        w_timer     = '0;
`ifdef UART_DEFRAMER_CHECKSUM_EN
                        w_xorAcc    = '0;
`endif
                    end else begin
                        w_nextState = S_HUNT;
                    end
                end else if (i_data_rdy) begin
                    w_overrunErr = 1'b1;
                end
            end
            default: begin
                w_nextState = S_HUNT;
            end
        endcase
    end

    assign o_pkt_data    = r_pktData;
    assign o_pkt_valid   = r_pktValid;
    assign o_pkt_count   = r_pktCount;
    assign o_timeout_err = r_timeoutErr;
    assign o_overrun_err = r_overrunErr;
`ifdef UART_DEFRAMER_CHECKSUM_EN
    assign o_chk_err     = r_chkErr;
`else
    assign o_chk_err     = 1'b0;
`endif

endmodule
